// File: rtl/adpll_mon_pkg.sv
// Shared types and constants for the ADPLL lock monitor.
package adpll_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } mon_state_e;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LOSS_CNT_W  = 8;

endpackage

// File: rtl/adpll_edge_sync.sv
// Brings one asynchronous clock into the fpga_clk domain and emits a
// single-cycle pulse for each rising edge.
module adpll_edge_sync
    import adpll_mon_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   pulse_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
            edge_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/adpll_lock_monitor.sv
// Gated-window frequency counter and lock tracker for the ADPLL node clocks.
// Optional per-node loss-of-lock counters: define ADPLL_LOCK_MON_LOSS_CNT_EN.
module adpll_lock_monitor
    import adpll_mon_pkg::*;
#(
    parameter int unsigned NUM_NODES    = 4,
    parameter int unsigned CNT_WIDTH    = 12,
    parameter int unsigned GATE_EDGES   = 256,
    parameter int unsigned LOCK_TOL     = 2,
    parameter int unsigned LOCK_WINDOWS = 4
) (
    input  logic                            fpga_clk_i,
    input  logic                            reset_i,
    input  logic                            enable_i,
    input  logic                            ref_i,
    input  logic [NUM_NODES-1:0]            node_clk_i,
    output logic [NUM_NODES*CNT_WIDTH-1:0]  count_o,
    output logic                            valid_o,
    output logic [NUM_NODES-1:0]            locked_o,
    output logic                            all_locked_o,
`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
    output logic [NUM_NODES*LOSS_CNT_W-1:0] loss_cnt_o,
`endif
    output logic [NUM_NODES-1:0]            overflow_o
);

    localparam int unsigned GOOD_W   = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned LO_BOUND = (GATE_EDGES > LOCK_TOL) ? GATE_EDGES - LOCK_TOL : 0;
    localparam int unsigned HI_BOUND = GATE_EDGES + LOCK_TOL;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 ref_pulse;
    logic [NUM_NODES-1:0] node_pulse;

    adpll_edge_sync u_ref_sync (
        .clk_i   (fpga_clk_i),
        .reset_i (reset_i),
        .async_i (ref_i),
        .pulse_o (ref_pulse)
    );

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_node_sync
        adpll_edge_sync u_node_sync (
            .clk_i   (fpga_clk_i),
            .reset_i (reset_i),
            .async_i (node_clk_i[g]),
            .pulse_o (node_pulse[g])
        );
    end

    mon_state_e                     state_q;
    logic [CNT_WIDTH-1:0]           ref_cnt_q;
    logic [CNT_WIDTH-1:0]           node_cnt_q [NUM_NODES];
    logic [NUM_NODES-1:0]           node_ovf_q;
    logic [GOOD_W-1:0]              good_q     [NUM_NODES];
    logic [NUM_NODES*CNT_WIDTH-1:0] count_q;
    logic                           valid_q;
    logic [NUM_NODES-1:0]           locked_q;
    logic [NUM_NODES-1:0]           ovf_out_q;
    logic                           all_locked_q;

    logic                           terminal_c;
    logic [NUM_NODES-1:0]           in_tol_c;
    logic [CNT_WIDTH-1:0]           cnt_inc_d  [NUM_NODES];
    logic [NUM_NODES-1:0]           ovf_inc_d;
    logic [GOOD_W-1:0]              good_d     [NUM_NODES];
    logic [NUM_NODES-1:0]           locked_d;

    // Saturating counter steps and tolerance verdict of the window now closing.
    always_comb begin
        terminal_c = enable_i && (state_q == ST_COUNT) && ref_pulse &&
                     (ref_cnt_q == CNT_WIDTH'(GATE_EDGES - 1));
        for (int unsigned n = 0; n < NUM_NODES; n++) begin
            cnt_inc_d[n] = node_cnt_q[n];
            ovf_inc_d[n] = node_ovf_q[n];
            if (node_pulse[n]) begin
                if (node_cnt_q[n] == CNT_MAX) begin
                    ovf_inc_d[n] = 1'b1;
                end else begin
                    cnt_inc_d[n] = node_cnt_q[n] + 1'b1;
                end
            end
            in_tol_c[n] = !node_ovf_q[n] &&
                          (32'(node_cnt_q[n]) >= LO_BOUND) &&
                          (32'(node_cnt_q[n]) <= HI_BOUND);
            good_d[n]   = '0;
            locked_d[n] = 1'b0;
            if (in_tol_c[n]) begin
                good_d[n]   = (good_q[n] == GOOD_W'(LOCK_WINDOWS)) ? good_q[n] : good_q[n] + 1'b1;
                locked_d[n] = (good_d[n] == GOOD_W'(LOCK_WINDOWS));
            end
        end
    end

    // Window FSM; the terminal edge both closes a window and opens the next.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            ref_cnt_q    <= '0;
            node_ovf_q   <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            locked_q     <= '0;
            ovf_out_q    <= '0;
            all_locked_q <= 1'b0;
            for (int unsigned n = 0; n < NUM_NODES; n++) begin
                node_cnt_q[n] <= '0;
                good_q[n]     <= '0;
            end
        end else begin
            valid_q      <= 1'b0;
            all_locked_q <= &locked_q;
            if (!enable_i) begin
                state_q    <= ST_IDLE;
                ref_cnt_q  <= '0;
                node_ovf_q <= '0;
                locked_q   <= '0;
                for (int unsigned n = 0; n < NUM_NODES; n++) begin
                    node_cnt_q[n] <= '0;
                    good_q[n]     <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_ARM;
                        ref_cnt_q  <= '0;
                        node_ovf_q <= '0;
                        for (int unsigned n = 0; n < NUM_NODES; n++) begin
                            node_cnt_q[n] <= '0;
                        end
                    end
                    ST_ARM: begin
                        if (ref_pulse) begin
                            state_q    <= ST_COUNT;
                            ref_cnt_q  <= '0;
                            node_ovf_q <= '0;
                            for (int unsigned n = 0; n < NUM_NODES; n++) begin
                                node_cnt_q[n] <= CNT_WIDTH'(node_pulse[n]);
                            end
                        end
                    end
                    ST_COUNT: begin
                        if (terminal_c) begin
                            valid_q    <= 1'b1;
                            ovf_out_q  <= node_ovf_q;
                            locked_q   <= locked_d;
                            ref_cnt_q  <= '0;
                            node_ovf_q <= '0;
                            for (int unsigned n = 0; n < NUM_NODES; n++) begin
                                count_q[n*CNT_WIDTH +: CNT_WIDTH] <= node_cnt_q[n];
                                good_q[n]     <= good_d[n];
                                node_cnt_q[n] <= CNT_WIDTH'(node_pulse[n]);
                            end
                        end else begin
                            if (ref_pulse) begin
                                ref_cnt_q <= ref_cnt_q + 1'b1;
                            end
                            node_ovf_q <= ovf_inc_d;
                            for (int unsigned n = 0; n < NUM_NODES; n++) begin
                                node_cnt_q[n] <= cnt_inc_d[n];
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_q [NUM_NODES];

    // Counts lock losses caused by a bad window; only reset clears it.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            for (int unsigned n = 0; n < NUM_NODES; n++) begin
                loss_q[n] <= '0;
            end
        end else if (terminal_c) begin
            for (int unsigned n = 0; n < NUM_NODES; n++) begin
                if (locked_q[n] && !in_tol_c[n] && (loss_q[n] != '1)) begin
                    loss_q[n] <= loss_q[n] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_loss_out
        assign loss_cnt_o[g*LOSS_CNT_W +: LOSS_CNT_W] = loss_q[g];
    end
`endif

    assign count_o      = count_q;
    assign valid_o      = valid_q;
    assign locked_o     = locked_q;
    assign all_locked_o = all_locked_q;
    assign overflow_o   = ovf_out_q;

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Directed bench for adpll_lock_monitor, scaled to a 16-edge gate window.
module tb_adpll_lock_monitor;

    localparam int unsigned NN = 4;
    localparam int unsigned CW = 8;

    logic            clk;
    logic            reset_i;
    logic            enable_i;
    logic            ref_i;
    logic [NN-1:0]   node_clk;
    logic [NN*CW-1:0] count;
    logic            valid;
    logic [NN-1:0]   locked;
    logic            all_locked;
    logic [NN-1:0]   ovf;
`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
    logic [NN*8-1:0] loss;
`endif

    adpll_lock_monitor #(
        .NUM_NODES    (NN),
        .CNT_WIDTH    (CW),
        .GATE_EDGES   (16),
        .LOCK_TOL     (2),
        .LOCK_WINDOWS (4)
    ) dut (
        .fpga_clk_i   (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .ref_i        (ref_i),
        .node_clk_i   (node_clk),
        .count_o      (count),
        .valid_o      (valid),
        .locked_o     (locked),
        .all_locked_o (all_locked),
`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
        .loss_cnt_o   (loss),
`endif
        .overflow_o   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vseen  = 0;
    logic            vd = 1'b0;
    logic [NN*CW-1:0] snap_count = '0;
    logic [NN-1:0]   snap_locked = '0;
    logic [NN-1:0]   snap_ovf = '0;
    logic            snap_all_v = 1'b0;
    logic            snap_all_next = 1'b0;

    // Capture outputs on each valid pulse and all_locked one cycle later.
    always @(negedge clk) begin
        if (vd) snap_all_next = all_locked;
        vd = valid;
        if (valid) begin
            vseen++;
            snap_count  = count;
            snap_locked = locked;
            snap_ovf    = ovf;
            snap_all_v  = all_locked;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NN*CW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    // One 4-cycle period: ref and selected nodes high for 2 cycles, low for 2.
    task automatic cyc(input logic r, input logic [NN-1:0] m);
        ref_i    = r;
        node_clk = m;
        repeat (2) @(negedge clk);
        ref_i    = 1'b0;
        node_clk = '0;
        repeat (2) @(negedge clk);
    endtask

    // 15 content ref edges, extra node-only edges, then the terminal ref edge.
    task automatic run_window(input int skip0, input int a0, input int a1, input int a2,
                              input int a3, input logic [NN-1:0] term_mask);
        int v0;
        int amax;
        logic [NN-1:0] m;
        v0 = vseen;
        for (int i = 1; i <= 15; i++) begin
            m = '1;
            if (i <= skip0) m[0] = 1'b0;
            cyc(1'b1, m);
        end
        amax = a0;
        if (a1 > amax) amax = a1;
        if (a2 > amax) amax = a2;
        if (a3 > amax) amax = a3;
        for (int k = 0; k < amax; k++) begin
            m[0] = (k < a0);
            m[1] = (k < a1);
            m[2] = (k < a2);
            m[3] = (k < a3);
            cyc(1'b0, m);
        end
        chk("no_early_valid", 64'(vseen), 64'(v0));
        cyc(1'b1, term_mask);
        repeat (2) @(negedge clk);
        chk("valid_pulse", 64'(vseen), 64'(v0 + 1));
    endtask

    task automatic chk_win(input string name, input logic [NN*CW-1:0] ec, input logic [NN-1:0] el,
                           input logic [NN-1:0] eo, input logic ea);
        chk({name, " count"},  snap_count,    ec);
        chk({name, " locked"}, snap_locked,   el);
        chk({name, " ovf"},    snap_ovf,      eo);
        chk({name, " all"},    snap_all_next, ea);
    endtask

    initial begin
        int v0;
        reset_i  = 1'b1;
        enable_i = 1'b0;
        ref_i    = 1'b0;
        node_clk = '0;
        repeat (3) @(negedge clk);
        chk("rst count", count, '0);
        chk("rst valid", valid, 1'b0);
        chk("rst locked", locked, '0);
        chk("rst all", all_locked, 1'b0);
        chk("rst ovf", ovf, '0);
`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
        chk("rst loss", loss, '0);
`endif
        reset_i = 1'b0;
        @(negedge clk);

        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        cyc(1'b1, 4'hF);

        // node0 -2 and node3 +2 sit on the tolerance edge; node2 +3 is outside
        for (int w = 1; w <= 4; w++) begin
            run_window(2, 0, 0, 3, 2, 4'hF);
            chk_win($sformatf("W%0d", w), pk(14, 16, 19, 18), (w == 4) ? 4'b1011 : 4'b0000, 4'b0000, 1'b0);
        end
        for (int w = 5; w <= 8; w++) begin
            run_window(0, 0, 0, 0, 0, 4'hF);
            chk_win($sformatf("W%0d", w), pk(16, 16, 16, 16), (w == 8) ? 4'b1111 : 4'b1011, 4'b0000, (w == 8));
        end
        chk("W8 all lag", snap_all_v, 1'b0);

        run_window(3, 0, 0, 0, 0, 4'hF);
        chk_win("W9", pk(13, 16, 16, 16), 4'b1110, 4'b0000, 1'b0);
        run_window(0, 0, 10, 0, 0, 4'hF);
        chk_win("W10", pk(16, 26, 16, 16), 4'b1100, 4'b0000, 1'b0);
        // node3 does not edge at the terminal ref edge: only the next window is short
        run_window(0, 0, 0, 0, 0, 4'b0111);
        chk_win("W11", pk(16, 16, 16, 16), 4'b1100, 4'b0000, 1'b0);
        run_window(0, 0, 0, 0, 0, 4'hF);
        chk_win("W12", pk(16, 16, 16, 15), 4'b1100, 4'b0000, 1'b0);
        run_window(0, 0, 0, 0, 0, 4'hF);
        chk_win("W13", pk(16, 16, 16, 16), 4'b1101, 4'b0000, 1'b0);
        run_window(0, 0, 0, 0, 0, 4'hF);
        chk_win("W14", pk(16, 16, 16, 16), 4'b1111, 4'b0000, 1'b1);
        run_window(0, 304, 0, 0, 0, 4'hF);
        chk_win("W15", pk(255, 16, 16, 16), 4'b1110, 4'b0001, 1'b0);
        run_window(0, 0, 1, 0, 0, 4'hF);
        chk_win("W16", pk(16, 17, 16, 16), 4'b1110, 4'b0000, 1'b0);
`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
        chk("loss after W16", loss, 32'h0000_0102);
`endif

        // partial window abandoned by dropping enable
        v0 = vseen;
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'hF);
        enable_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("dis no valid", 64'(vseen), 64'(v0));
        chk("dis valid", valid, 1'b0);
        chk("dis locked", locked, '0);
        chk("dis all", all_locked, 1'b0);
        chk("dis count hold", count, pk(16, 17, 16, 16));
        chk("dis ovf hold", ovf, '0);
`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
        chk("dis loss hold", loss, 32'h0000_0102);
`endif

        // re-arm: node edges while armed are ignored
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        cyc(1'b0, 4'b0100);
        cyc(1'b0, 4'b0100);
        cyc(1'b1, 4'hF);
        run_window(0, 0, 0, 0, 0, 4'hF);
        chk_win("REARM", pk(16, 16, 16, 16), 4'b0000, 4'b0000, 1'b0);

        // reset in the middle of a window
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'hF);
        reset_i = 1'b1;
        @(negedge clk);
        chk("mid rst count", count, '0);
        chk("mid rst valid", valid, 1'b0);
        chk("mid rst locked", locked, '0);
        chk("mid rst all", all_locked, 1'b0);
        chk("mid rst ovf", ovf, '0);
`ifdef ADPLL_LOCK_MON_LOSS_CNT_EN
        chk("mid rst loss", loss, '0);
`endif
        reset_i  = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adpll_lock_monitor.md
Name: adpll_lock_monitor

Overview:
- Receive end of the ADPLL network test interface: samples the external/generated reference and each node's divided output (gen_div8) in the fpga_clk domain.
- Counts node edges against a gated window of reference edges and reports per-node frequency counts, lock status and loss-of-lock flags.
- Sits beside the 2x2 ring network in the test top and feeds the 7-seg/debug paths.

Parameters:
- NUM_NODES, 4, number of node clocks monitored
- CNT_WIDTH, 12, width of each per-node edge counter (saturating)
- GATE_EDGES, 256, reference rising edges per measurement window (must be >= 2 and < 2^CNT_WIDTH)
- LOCK_TOL, 2, max |node_count - GATE_EDGES| for a window to count as in-tolerance
- LOCK_WINDOWS, 4, consecutive in-tolerance windows needed to assert lock

Ports:
- fpga_clk_i  in  1  system clock (258 MHz domain)
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  0 = idle/clear, 1 = measure
- ref_i  in  1  asynchronous reference clock
- node_clk_i  in  NUM_NODES  asynchronous node div8 clocks; bit n = node n
- count_o  out  NUM_NODES*CNT_WIDTH  last window's counts; node n in [n*CNT_WIDTH +: CNT_WIDTH]
- valid_o  out  1  one-cycle pulse when count_o/locked_o update
- locked_o  out  NUM_NODES  per-node lock flag
- all_locked_o  out  1  AND of locked_o
- overflow_o  out  NUM_NODES  per-node counter saturated in last window

Behaviour:
- One clock; reset is synchronous and active-high (fpga_clk_i / reset_i).
- Input conditioning: each async input passes through a 2-FF synchronizer plus an edge-register stage. A rising-edge pulse is produced 3 cycles after the input transition is first sampled.
- FSM states are IDLE, ARM, COUNT.
  - IDLE: counters held at 0. Moves to ARM when enable_i = 1.
  - ARM: waits for the first ref edge pulse; on that edge moves to COUNT with ref_cnt = 0 and node counters = 0. Node edges seen in ARM are ignored.
  - COUNT: each ref edge pulse increments ref_cnt; each node edge pulse increments that node's counter, saturating at 2^CNT_WIDTH-1 and setting an internal overflow bit.
  - Terminal edge: when ref_cnt reaches GATE_EDGES on a ref edge, in that same cycle:
    - latch counts into count_o and overflow bits into overflow_o;
    - pulse valid_o on the next cycle;
    - restart the window (ref_cnt = 0, node counters = 0 or 1 if that node edged this cycle). Consecutive windows have no gap.
- Simultaneous events:
  - Node edge in the same cycle as the terminal ref edge: counted in the NEW window, not the closing one.
  - Node edge in the same cycle as the ARM-exit ref edge: counted (counter = 1).
- Lock tracking, per node, updated when valid_o is asserted:
  - in_tol = !overflow && |count - GATE_EDGES| <= LOCK_TOL.
  - in_tol: good_cnt increments, saturating at LOCK_WINDOWS. Not in_tol: good_cnt = 0 and locked_o[n] = 0.
  - locked_o[n] = 1 when good_cnt reaches LOCK_WINDOWS.
- Difference arithmetic: unsigned compare of count against GATE_EDGES ± LOCK_TOL. Clamp the lower bound at 0. Apply no wrap.
- enable_i falling, in any state: next cycle goes to IDLE.
  - Cleared: counters, good_cnt, locked_o.
  - Held: count_o, overflow_o.
  - A partial window is discarded and valid_o is not pulsed.
- Reset values: count_o = 0, valid_o = 0, locked_o = 0, all_locked_o = 0, overflow_o = 0, FSM = IDLE, synchronizers = 0. Reset mid-window discards the window.
- all_locked_o is registered and lags locked_o by one cycle.

Optional Feature:
- Macro ADPLL_LOCK_MON_LOSS_CNT_EN.
- When defined:
  - Adds output loss_cnt_o [NUM_NODES*8], an 8-bit saturating counter per node.
  - The counter increments on each locked_o[n] 1->0 transition caused by an out-of-tolerance window.
  - The counter clears on reset_i only; enable_i does not clear it.
- When undefined: the port and logic are absent.

Decomposition:
- Shared package adpll_mon_pkg holds:
  - the FSM state enum (IDLE/ARM/COUNT);
  - the synchronizer depth constant (2);
  - the loss-counter width constant (8).
- Sub-module adpll_edge_sync is instantiated once per input (NUM_NODES+1 copies). It contains the 2-FF synchronizer, the edge register and the rising-edge pulse output.

Test Plan:
- Reference at 258/200 MHz and all nodes at the same frequency, GATE_EDGES = 256 → every window gives count = 256 and valid_o pulses. locked_o = 4'b1111 after the 4th valid_o; all_locked_o follows one cycle later.
- Node 2 at 2% higher frequency (count about 261) → locked_o[2] stays 0 while the other nodes lock. With ADPLL_LOCK_MON_LOSS_CNT_EN defined, loss_cnt_o[2] = 0.
- Lock all nodes, then drive 10 extra edges into node 1 in one window → the window reports count 266 and locked_o[1] drops at that valid_o. Relock needs 4 more good windows; loss_cnt_o[1] = 1 (macro on).
- Node 0 at 20x the reference frequency with CNT_WIDTH = 12 → count_o node 0 = 4095, overflow_o[0] = 1, locked_o[0] = 0.
- Drop enable_i at ref edge 100 of a window → no valid_o, locked_o cleared, count_o holds the previous values. Re-enable → ARM, and the first valid_o comes 256 ref edges after the next ref edge.
- Node edge forced coincident with the terminal ref edge → that edge appears in the next window's count, not the closing one. Assert reset_i mid-window → all outputs zero the next cycle.
